// File: rtl/univ_shift_reg_pkg.sv
// Shared types and limits for the universal shift register.
// Mode encoding is fixed; the ordering matches the input_mode pin assignment.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int unsigned MAX_WIDTH = 64;

    // True for the two modes that move data between cells.
    function automatic logic is_shift_mode(mode_t mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_cell.sv
// One bit of the universal shift register: DFF with enable, sync reset and a
// 4:1 next-state mux (hold, upper neighbour, lower neighbour, parallel data).
module univ_shift_reg_cell
    import univ_shift_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_t mode,
    input  logic  shr_in,  // bit arriving on shift right (from the next-higher cell)
    input  logic  shl_in,  // bit arriving on shift left (from the next-lower cell)
    input  logic  d,
    output logic  q
);

    // Declaration initialiser gives the power-up value on FPGA targets.
    logic q_q = RESET_BIT;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = shr_in;
                MODE_SHL:  q_d = shl_in;
                MODE_LOAD: q_d = d;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load).
// Define UNIV_SHIFT_REG_ROTATE_EN to add input_rotate, turning shifts into rotates.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             input_clock1_clk_1,
    input  logic             input_push_button2_rst_2,
    input  logic             input_en,
    input  logic [1:0]       input_mode,
    input  logic             input_sin_r,
    input  logic             input_sin_l,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             input_rotate,
`endif
    input  logic [WIDTH-1:0] input_d,
    output logic [WIDTH-1:0] output_q,
    output logic [WIDTH-1:0] output_q_n,
    output logic             output_sout_r,
    output logic             output_sout_l,
    output logic             output_zero
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : gen_width_check
        $error("univ_shift_reg: WIDTH out of range");
    end

    mode_t            mode;
    logic             rotate;
    logic             end_shr_in;
    logic             end_shl_in;
    logic [WIDTH-1:0] q;

    assign mode = mode_t'(input_mode);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign rotate = input_rotate;
`else
    assign rotate = 1'b0;
`endif

    // End cells take either the serial input or the bit wrapping around.
    // For WIDTH=1 both wraps select q[0], so a rotate holds.
    assign end_shr_in = rotate ? q[0]       : input_sin_r;
    assign end_shl_in = rotate ? q[WIDTH-1] : input_sin_l;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
        logic shr_src;
        logic shl_src;

        if (i == WIDTH - 1) begin : gen_top_end
            assign shr_src = end_shr_in;
        end else begin : gen_top_mid
            assign shr_src = q[i+1];
        end

        if (i == 0) begin : gen_bot_end
            assign shl_src = end_shl_in;
        end else begin : gen_bot_mid
            assign shl_src = q[i-1];
        end

        univ_shift_reg_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk    (input_clock1_clk_1),
            .rst    (input_push_button2_rst_2),
            .en     (input_en),
            .mode   (mode),
            .shr_in (shr_src),
            .shl_in (shl_src),
            .d      (input_d[i]),
            .q      (q[i])
        );
    end

    // Outputs depend on register state only; no input-to-output path.
    assign output_q      = q;
    assign output_q_n    = ~q;
    assign output_sout_r = q[0];
    assign output_sout_l = q[WIDTH-1];
    assign output_zero   = (q == '0);

endmodule
